lane_rx: RTL and testbench
==========================

# lane_rx

Receive-side lane block for the JESD204B-style serial link. It takes decoded 8b/10b octets plus a control-character flag from one lane, runs code-group synchronization (CGS) and drives `sync_n`, then checks the initial lane alignment sequence (ILA) and captures its link configuration. In the data phase it undoes /F/ and /A/ character replacement and delivers frame-aligned payload octets to the receive transport layer. It is the far-end counterpart of the transmit lane (CGS → ILA → data mux).

## Interface
Parameters:
- `F`, 2: octets per frame (1..16).
- `K`, 16: frames per multiframe. Requires F*K ≥ 17 and F*K ≤ 1024.
- `CGS_CNT`, 4: consecutive /K/ needed to declare sync.

Ports:
- `clk`  in  1  lane octet clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `lane_data_in`  in  8  received octet.
- `lane_data_comma`  in  1  1 = octet is a control (K) character.
- `sync_n`  out  1  JESD SYNC~; low requests CGS.
- `rx_data`  out  8  payload octet after character replacement is undone.
- `rx_valid`  out  1  `rx_data` is valid; high only in DATA.
- `rx_frame_start`  out  1  qualifies the first octet of a frame.
- `rx_mf_start`  out  1  qualifies the first octet of a multiframe.
- `cfg_did`  out  8  device ID, from ILA config octet 0.
- `cfg_lid`  out  5  lane ID, from ILA config octet 2 bits [4:0].
- `cfg_valid`  out  1  config captured; held until the next CGS.
- `align_err`  out  1  one-cycle pulse: /F/ or /A/ at an illegal position.
- `ila_err`  out  1  one-cycle pulse: ILA sequence violated.
- `state`  out  2  FSM state, for debug.

The block uses one clock; reset is asynchronous and active-low.

## Operation
Control characters (only valid with `lane_data_comma` = 1):
- /K/ = 0xBC
- /R/ = 0x1C
- /A/ = 0x7C
- /Q/ = 0x9C
- /F/ = 0xFC

FSM states:
- **CGS_WAIT (0).** `sync_n` = 0. A counter tracks consecutive /K/ and any other octet clears it. When the counter reaches `CGS_CNT`, go to CGS_SYNC.
- **CGS_SYNC (1).** `sync_n` = 1.
  - /K/: stay.
  - /R/: go to ILA. This octet is position 0 of ILA multiframe 0.
  - Anything else: pulse `ila_err` and return to CGS_WAIT.
- **ILA (2).** Checks four multiframes using octet counter `oc` (0..F-1), frame counter `fc` (0..K-1) and multiframe counter `mc` (0..3). Position p = fc·F + oc. Required content:
  - p = 0: /R/.
  - p = F*K-1: /A/.
  - In mc = 1 only: p = 1 is /Q/, and p = 2..15 are config octets, which must not be control characters.
  - All other positions: don't-care data.
  - Any violation: pulse `ila_err`, clear `cfg_valid`, return to CGS_WAIT.
  - Capture `cfg_did` at p = 2 and `cfg_lid` at p = 4. Set `cfg_valid` at the end of mc = 1.
  - At the end of mc = 3, go to DATA. The counters wrap to 0.
- **DATA (3).** Counters free-run and wrap.
  - /A/ at p = F*K-1, or /F/ at oc = F-1 with p ≠ F*K-1: output a copy of the last octet of the previous frame. Keep a register `last_oct`, loaded at every oc = F-1, including replaced octets.
  - /A/ or /F/ at any other position: pulse `align_err`, output the raw octet, state unchanged.
  - `CGS_CNT` consecutive /K/: return to CGS_WAIT and clear `cfg_valid`.

## Timing
- Reset values:
  - `sync_n` = 0.
  - `rx_data` = 0.
  - All valid/start/err outputs = 0.
  - `cfg_*` = 0.
  - `state` = CGS_WAIT.
  - All counters = 0.
- All outputs are registered. `rx_*` lag `lane_data_in` by exactly one cycle.
- `sync_n` rises in the cycle after the `CGS_CNT`-th /K/ is sampled, and falls in the cycle after the error or loss event.
- `rx_valid` is first high for the octet immediately after the final ILA /A/, so there are no gaps at that boundary.
- `rx_frame_start` = `rx_valid` & (oc = 0). `rx_mf_start` = `rx_valid` & (p = 0).
- Reset asserted mid-operation immediately forces the reset values; no partial ILA state survives.
- In a /K/ run broken by one non-/K/, the count restarts from 0.

## Structure
- Package `lane_rx_pkg` holds:
  - the K-character constants;
  - the state enum;
  - the ILA constants: multiframe count 4, config offset 2, config length 14.
- Sub-module `lane_rx_ila` (natural split) does the ILA position checking and config capture, and returns done/err to the top FSM.
- Counter widths are $clog2(F), $clog2(K) and 2 bits.

## Test plan
Defaults F = 2, K = 16, so one multiframe is 32 octets.
1. Reset, then 3 /K/, one 0x00, then 4 /K/ → `sync_n` stays 0 through the first group and rises 1 cycle after the 7th /K/ is sampled.
2. Clean CGS, then 4 ILA multiframes with DID = 0x5A and LID octet = 0x03 → `cfg_did` = 0x5A, `cfg_lid` = 3, `cfg_valid` set after octet 63. `rx_valid` rises for octet 128 with `rx_mf_start` = 1.
3. ILA with 0x9C missing at mc = 1, p = 1 → `ila_err` pulse, `sync_n` = 0 next cycle, `cfg_valid` = 0.
4. DATA: frame 0x11,0x22, then octets 0x33 and /F/ → the second output of that frame is 0x22. /A/ at p = 31 after a frame ending 0x44 → output 0x44.
5. DATA: /F/ at oc = 0 → `align_err` pulse, `rx_data` = 0xFC, still in DATA.
6. DATA: 4 consecutive /K/ → state CGS_WAIT, `sync_n` = 0, `rx_valid` = 0. Assert reset mid-ILA → all outputs return to their reset values.

Source files
------------

// File: rtl/lane_rx_pkg.sv
// Shared constants and types for the JESD204B-style receive lane.
package lane_rx_pkg;

    localparam logic [7:0] CHAR_K = 8'hBC;
    localparam logic [7:0] CHAR_R = 8'h1C;
    localparam logic [7:0] CHAR_A = 8'h7C;
    localparam logic [7:0] CHAR_Q = 8'h9C;
    localparam logic [7:0] CHAR_F = 8'hFC;

    localparam int ILA_MF_CNT  = 4;
    localparam int ILA_CFG_OFS = 2;
    localparam int ILA_CFG_LEN = 14;

    typedef enum logic [1:0] {
        CGS_WAIT = 2'd0,
        CGS_SYNC = 2'd1,
        ILA      = 2'd2,
        DATA     = 2'd3
    } lane_state_e;

    // True when the octet is the given control character.
    function automatic logic is_char(input logic comma, input logic [7:0] data,
                                     input logic [7:0] ch);
        return comma && (data == ch);
    endfunction

endpackage

// File: rtl/lane_rx_ila.sv
// ILA position checker and link-configuration capture.
module lane_rx_ila
    import lane_rx_pkg::*;
#(
    parameter int PW = 5
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          active,
    input  logic          clr,
    input  logic [7:0]    data,
    input  logic          comma,
    input  logic [PW-1:0] p,
    input  logic          p_last,
    input  logic [1:0]    mc,
    output logic          err,
    output logic          done,
    output logic [7:0]    cfg_did,
    output logic [4:0]    cfg_lid,
    output logic          cfg_valid
);

    logic viol;
    logic cfg_mf;
    logic in_cfg;

    // Required content of the current ILA position; only mc = 1 carries config.
    always_comb begin
        cfg_mf = (mc == 2'd1);
        in_cfg = cfg_mf && (p >= PW'(ILA_CFG_OFS)) && (p < PW'(ILA_CFG_OFS + ILA_CFG_LEN));
        viol   = 1'b0;
        if (p == '0)
            viol = !is_char(comma, data, CHAR_R);
        else if (p_last)
            viol = !is_char(comma, data, CHAR_A);
        else if (cfg_mf && (p == PW'(1)))
            viol = !is_char(comma, data, CHAR_Q);
        else if (in_cfg)
            viol = comma;
        err  = active && viol;
        done = active && !viol && p_last && (mc == 2'(ILA_MF_CNT - 1));
    end

    // Capture DID/LID from the config multiframe; valid once that multiframe closes cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_did   <= 8'h00;
            cfg_lid   <= 5'h00;
            cfg_valid <= 1'b0;
        end else begin
            if (active && cfg_mf && (p == PW'(ILA_CFG_OFS)))
                cfg_did <= data;
            if (active && cfg_mf && (p == PW'(ILA_CFG_OFS + 2)))
                cfg_lid <= data[4:0];
            if (clr)
                cfg_valid <= 1'b0;
            else if (active && !viol && cfg_mf && p_last)
                cfg_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/lane_rx.sv
// Receive lane: CGS / ILA / DATA sequencing with /F/ and /A/ replacement undone.
//   state    | meaning
//   CGS_WAIT | sync_n low, counting consecutive /K/
//   CGS_SYNC | sync_n high, waiting for /R/ that opens the ILA
//   ILA      | checking four ILA multiframes, capturing config
//   DATA     | delivering payload, watching for /K/ loss of sync
module lane_rx
    import lane_rx_pkg::*;
#(
    parameter int F       = 2,
    parameter int K       = 16,
    parameter int CGS_CNT = 4
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] lane_data_in,
    input  logic       lane_data_comma,
    output logic       sync_n,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_start,
    output logic       rx_mf_start,
    output logic [7:0] cfg_did,
    output logic [4:0] cfg_lid,
    output logic       cfg_valid,
    output logic       align_err,
    output logic       ila_err,
    output logic [1:0] state
);

    localparam int OW = (F > 1) ? $clog2(F) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = $clog2(F * K);
    localparam int CW = $clog2(CGS_CNT + 1);

    lane_state_e   state_q, state_nx;
    logic [OW-1:0] oc, oc_nx;
    logic [KW-1:0] fc, fc_nx;
    logic [1:0]    mc, mc_nx;
    logic [CW-1:0] k_cnt;
    logic [PW-1:0] p;
    logic          oc_last, p_last;
    logic          is_k, is_r, is_a, is_f, k_run_done;
    logic          sync_err, ila_chk_err, ila_done, cfg_clr;
    logic          replace, misplaced, out_valid;
    logic [7:0]    data_out, last_oct;

    assign is_k       = is_char(lane_data_comma, lane_data_in, CHAR_K);
    assign is_r       = is_char(lane_data_comma, lane_data_in, CHAR_R);
    assign is_a       = is_char(lane_data_comma, lane_data_in, CHAR_A);
    assign is_f       = is_char(lane_data_comma, lane_data_in, CHAR_F);
    assign k_run_done = is_k && (k_cnt == CW'(CGS_CNT - 1));
    assign oc_last    = (oc == OW'(F - 1));
    assign p_last     = oc_last && (fc == KW'(K - 1));
    assign p          = PW'(fc) * PW'(F) + PW'(oc);
    assign state      = state_q;
    assign cfg_clr    = (state_q != CGS_WAIT) && (state_nx == CGS_WAIT);
    assign out_valid  = (state_q == DATA) && (state_nx == DATA);

    lane_rx_ila #(.PW(PW)) u_ila (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (state_q == ILA),
        .clr       (cfg_clr),
        .data      (lane_data_in),
        .comma     (lane_data_comma),
        .p         (p),
        .p_last    (p_last),
        .mc        (mc),
        .err       (ila_chk_err),
        .done      (ila_done),
        .cfg_did   (cfg_did),
        .cfg_lid   (cfg_lid),
        .cfg_valid (cfg_valid)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= CGS_WAIT;
        else        state_q <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state_q;
        sync_err = 1'b0;
        case (state_q)
            CGS_WAIT: if (k_run_done) state_nx = CGS_SYNC;
            CGS_SYNC: begin
                if (is_r) begin
                    state_nx = ILA;
                end else if (!is_k) begin
                    state_nx = CGS_WAIT;
                    sync_err = 1'b1;
                end
            end
            ILA: begin
                if (ila_chk_err)   state_nx = CGS_WAIT;
                else if (ila_done) state_nx = DATA;
            end
            DATA:     if (k_run_done) state_nx = CGS_WAIT;
            default:  state_nx = CGS_WAIT;
        endcase
    end

    // Position counters advance one octet; counters sit at 0 outside ILA/DATA so the /R/ is p = 0.
    always_comb begin
        oc_nx = oc;
        fc_nx = fc;
        mc_nx = mc;
        if (oc_last) begin
            oc_nx = '0;
            if (fc == KW'(K - 1)) begin
                fc_nx = '0;
                mc_nx = mc + 2'd1;
            end else begin
                fc_nx = fc + KW'(1);
            end
        end else begin
            oc_nx = oc + OW'(1);
        end
    end

    // /F/ and /A/ are only legal at frame / multiframe ends; there they stand for the previous frame's last octet.
    always_comb begin
        replace   = (is_a && p_last) || (is_f && oc_last && !p_last);
        misplaced = (is_a || is_f) && !replace;
        data_out  = replace ? last_oct : lane_data_in;
    end

    // Counter and /K/ run-length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oc    <= '0;
            fc    <= '0;
            mc    <= '0;
            k_cnt <= '0;
        end else begin
            if ((state_nx == ILA) || (state_nx == DATA)) begin
                oc <= oc_nx;
                fc <= fc_nx;
                mc <= mc_nx;
            end else begin
                oc <= '0;
                fc <= '0;
                mc <= '0;
            end
            if (((state_q == CGS_WAIT) || (state_q == DATA)) && is_k && !k_run_done)
                k_cnt <= k_cnt + CW'(1);
            else
                k_cnt <= '0;
        end
    end

    // Registered outputs; rx_* lag the input octet by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_n         <= 1'b0;
            rx_data        <= 8'h00;
            rx_valid       <= 1'b0;
            rx_frame_start <= 1'b0;
            rx_mf_start    <= 1'b0;
            align_err      <= 1'b0;
            ila_err        <= 1'b0;
            last_oct       <= 8'h00;
        end else begin
            sync_n         <= (state_nx != CGS_WAIT);
            rx_valid       <= out_valid;
            rx_data        <= out_valid ? data_out : 8'h00;
            rx_frame_start <= out_valid && (oc == '0);
            rx_mf_start    <= out_valid && (p == '0);
            align_err      <= (state_q == DATA) && misplaced;
            ila_err        <= sync_err || ila_chk_err;
            if ((state_q == DATA) && oc_last)
                last_oct <= data_out;
        end
    end

endmodule

// File: tb/tb_lane_rx.sv
// Directed bench for lane_rx with F = 2, K = 16, CGS_CNT = 4 (32-octet multiframes).
module tb_lane_rx;

    logic       clk, rst_n;
    logic [7:0] din;
    logic       comma;
    logic       sync_n, rx_valid, rx_fs, rx_mf, cfg_valid, align_err, ila_err;
    logic [7:0] rx_data, cfg_did;
    logic [4:0] cfg_lid;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    lane_rx #(.F(2), .K(16), .CGS_CNT(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lane_data_in    (din),
        .lane_data_comma (comma),
        .sync_n          (sync_n),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_frame_start  (rx_fs),
        .rx_mf_start     (rx_mf),
        .cfg_did         (cfg_did),
        .cfg_lid         (cfg_lid),
        .cfg_valid       (cfg_valid),
        .align_err       (align_err),
        .ila_err         (ila_err),
        .state           (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic [7:0] e_data;
        logic       e_fs;
        logic       e_mf;
        logic       e_aerr;
    } vec_t;

    vec_t vt [64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic c);
        @(negedge clk);
        din   = d;
        comma = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_k4();
        for (int i = 0; i < 4; i++) send(8'hBC, 1'b1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sync_n"},    sync_n,    0);
        chk({tag, "_rx_data"},   rx_data,   0);
        chk({tag, "_rx_valid"},  rx_valid,  0);
        chk({tag, "_rx_fs"},     rx_fs,     0);
        chk({tag, "_rx_mf"},     rx_mf,     0);
        chk({tag, "_cfg_did"},   cfg_did,   0);
        chk({tag, "_cfg_lid"},   cfg_lid,   0);
        chk({tag, "_cfg_valid"}, cfg_valid, 0);
        chk({tag, "_align_err"}, align_err, 0);
        chk({tag, "_ila_err"},   ila_err,   0);
        chk({tag, "_state"},     state,     0);
    endtask

    // Octet i (0..127) of a legal ILA; returns {comma, data}.
    function automatic logic [8:0] ila_oct(input int i, input logic [7:0] did, input logic [7:0] lid);
        int m = i / 32;
        int p = i % 32;
        if (p == 0)            return {1'b1, 8'h1C};
        if (p == 31)           return {1'b1, 8'h7C};
        if (m == 1 && p == 1)  return {1'b1, 8'h9C};
        if (m == 1 && p == 2)  return {1'b0, did};
        if (m == 1 && p == 4)  return {1'b0, lid};
        return {1'b0, 8'(i)};
    endfunction

    task automatic ov(input int i, input logic [7:0] d, input logic c, input logic [7:0] e, input logic ae);
        vt[i].d      = d;
        vt[i].c      = c;
        vt[i].e_data = e;
        vt[i].e_aerr = ae;
    endtask

    initial begin
        logic [8:0] o;
        int ierr_seen;

        // DATA-phase vectors: two multiframes, plain octets unless overridden.
        for (int i = 0; i < 64; i++) begin
            vt[i].d      = 8'(i + 1);
            vt[i].c      = 1'b0;
            vt[i].e_data = 8'(i + 1);
            vt[i].e_fs   = (i % 2 == 0);
            vt[i].e_mf   = (i % 32 == 0);
            vt[i].e_aerr = 1'b0;
        end
        ov(0,  8'h11, 0, 8'h11, 0);
        ov(1,  8'h22, 0, 8'h22, 0);
        ov(2,  8'h33, 0, 8'h33, 0);
        ov(3,  8'hFC, 1, 8'h22, 0);   // /F/ at frame end -> previous frame's last octet
        ov(4,  8'hFC, 1, 8'hFC, 1);   // /F/ at oc = 0 is misplaced
        ov(5,  8'h55, 0, 8'h55, 0);
        ov(29, 8'h44, 0, 8'h44, 0);
        ov(30, 8'h66, 0, 8'h66, 0);
        ov(31, 8'h7C, 1, 8'h44, 0);   // /A/ at multiframe end
        ov(32, 8'h7C, 1, 8'h7C, 1);   // /A/ at p = 0 is misplaced
        ov(33, 8'hFC, 1, 8'h44, 0);   // last_oct holds the replaced 0x44
        ov(34, 8'h77, 0, 8'h77, 0);
        ov(35, 8'h7C, 1, 8'h7C, 1);   // /A/ at frame end but not multiframe end
        ov(62, 8'h88, 0, 8'h88, 0);
        ov(63, 8'hFC, 1, 8'hFC, 1);   // /F/ at multiframe end is misplaced

        // Reset values
        rst_n = 1'b0;
        din   = 8'h00;
        comma = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: broken /K/ run restarts the count
        for (int i = 0; i < 3; i++) begin
            send(8'hBC, 1'b1);
            chk($sformatf("t1_k%0d_sync_n", i), sync_n, 0);
        end
        send(8'h00, 1'b0);
        chk("t1_break_sync_n", sync_n, 0);
        for (int i = 0; i < 3; i++) begin
            send(8'hBC, 1'b1);
            chk($sformatf("t1_k2_%0d_sync_n", i), sync_n, 0);
        end
        send(8'hBC, 1'b1);
        chk("t1_sync_n_rise", sync_n, 1);
        chk("t1_state_sync", state, 1);
        send(8'hBC, 1'b1);
        chk("t1_extra_k_state", state, 1);

        // 2: full ILA
        ierr_seen = 0;
        for (int i = 0; i < 128; i++) begin
            o = ila_oct(i, 8'h5A, 8'h03);
            send(o[7:0], o[8]);
            if (ila_err) ierr_seen++;
            if (i == 0)   chk("t2_state_ila", state, 2);
            if (i == 62)  chk("t2_cfg_valid_early", cfg_valid, 0);
            if (i == 63)  chk("t2_cfg_valid_set", cfg_valid, 1);
            if (i == 126) chk("t2_state_ila_end", state, 2);
        end
        chk("t2_no_ila_err", ierr_seen, 0);
        chk("t2_state_data", state, 3);
        chk("t2_no_valid_yet", rx_valid, 0);
        chk("t2_cfg_did", cfg_did, 8'h5A);
        chk("t2_cfg_lid", cfg_lid, 5'd3);
        chk("t2_sync_n", sync_n, 1);

        // 4/5: DATA vectors
        for (int i = 0; i < 64; i++) begin
            send(vt[i].d, vt[i].c);
            chk($sformatf("data%0d_rx_data", i), rx_data, vt[i].e_data);
            chk($sformatf("data%0d_valid", i), rx_valid, 1);
            chk($sformatf("data%0d_fs", i), rx_fs, vt[i].e_fs);
            chk($sformatf("data%0d_mf", i), rx_mf, vt[i].e_mf);
            chk($sformatf("data%0d_aerr", i), align_err, vt[i].e_aerr);
            chk($sformatf("data%0d_state", i), state, 3);
        end

        // 6: loss of sync in DATA
        send(8'hBC, 1'b1);
        chk("t6_k1_data", rx_data, 8'hBC);
        chk("t6_k1_mf", rx_mf, 1);
        send(8'hBC, 1'b1);
        send(8'hBC, 1'b1);
        chk("t6_k3_valid", rx_valid, 1);
        chk("t6_k3_state", state, 3);
        send(8'hBC, 1'b1);
        chk("t6_state", state, 0);
        chk("t6_sync_n", sync_n, 0);
        chk("t6_valid", rx_valid, 0);
        chk("t6_cfg_valid", cfg_valid, 0);

        // CGS_SYNC followed by junk
        send_k4();
        chk("t3a_sync_n", sync_n, 1);
        send(8'h00, 1'b0);
        chk("t3a_ila_err", ila_err, 1);
        chk("t3a_state", state, 0);
        chk("t3a_sync_n_low", sync_n, 0);

        // 3: /Q/ missing at mc = 1, p = 1
        send_k4();
        for (int i = 0; i < 33; i++) begin
            o = ila_oct(i, 8'h5A, 8'h03);
            send(o[7:0], o[8]);
        end
        chk("t3_no_err_before", ila_err, 0);
        send(8'h00, 1'b0);
        chk("t3_ila_err", ila_err, 1);
        chk("t3_sync_n", sync_n, 0);
        chk("t3_state", state, 0);
        chk("t3_cfg_valid", cfg_valid, 0);
        send(8'h00, 1'b0);
        chk("t3_err_pulse", ila_err, 0);

        // Error after config captured clears cfg_valid
        send_k4();
        for (int i = 0; i < 64; i++) begin
            o = ila_oct(i, 8'hA5, 8'hFF);
            send(o[7:0], o[8]);
        end
        chk("t3b_cfg_valid", cfg_valid, 1);
        chk("t3b_cfg_lid", cfg_lid, 5'h1F);
        chk("t3b_cfg_did", cfg_did, 8'hA5);
        send(8'h00, 1'b0);   // mc = 2, p = 0 must be /R/
        chk("t3b_ila_err", ila_err, 1);
        chk("t3b_cfg_cleared", cfg_valid, 0);

        // 6b: asynchronous reset mid-ILA
        send_k4();
        for (int i = 0; i < 70; i++) begin
            o = ila_oct(i, 8'h5A, 8'h03);
            send(o[7:0], o[8]);
        end
        chk("t6b_pre_state", state, 2);
        chk("t6b_pre_cfg_valid", cfg_valid, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h1C, 1'b1);
        chk("t6b_post_state", state, 0);
        chk("t6b_post_sync_n", sync_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
